branch_predictor_bht: RTL and testbench

// - Parametrised successor to the fixed-rule branch predictor in the 5-stage RISC-V pipeline.
// - Direct-mapped branch target buffer with a per-entry N-bit saturating direction counter.
// - Lookup is indexed by the IF-stage PC and answers in the same cycle.
// - Updates come from ID once a branch resolves, with flush support and perf counters.

---
 rtl/riscv_bp_pkg.sv | 27 ++
 rtl/bp_sat_counter.sv | 29 ++
 rtl/branch_predictor_bht.sv | 95 +++++++++
 tb/tb_branch_predictor_bht.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_bp_pkg.sv
// Shared helpers for the branch predictor: PC field split and width-generic saturating arithmetic.
package riscv_bp_pkg;

  localparam int unsigned INST_BYTES = 4;

  // All helpers work on 64-bit values; callers size-cast the result back to their field width.
  function automatic logic [63:0] sat_max(input int unsigned w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    return (v >= sat_max(w)) ? sat_max(w) : v + 64'd1;
  endfunction

  function automatic logic [63:0] sat_dec(input logic [63:0] v);
    return (v == 64'd0) ? 64'd0 : v - 64'd1;
  endfunction

  function automatic logic [63:0] bp_idx(input logic [63:0] pc, input int unsigned idx_w);
    return (pc >> 2) & sat_max(idx_w);
  endfunction

  function automatic logic [63:0] bp_tag(input logic [63:0] pc, input int unsigned idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up/down direction counter for one predictor entry; load wins over inc/dec.
module bp_sat_counter
  import riscv_bp_pkg::*;
#(
  parameter int unsigned      CNT_W   = 2,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_inc, cnt_dec;

  assign cnt_inc = CNT_W'(sat_inc(64'(cnt), CNT_W));
  assign cnt_dec = CNT_W'(sat_dec(64'(cnt)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= RST_VAL;
    else if (load) cnt <= load_val;
    else if (inc)  cnt <= cnt_inc;
    else if (dec)  cnt <= cnt_dec;
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped BTB with per-entry saturating direction counters, same-cycle lookup,
// flush-all and saturating performance counters.
module branch_predictor_bht
  import riscv_bp_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispredict,
  input  logic              flush,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));

  logic [ENTRIES-1:0]             valid;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag_q;
  logic [ENTRIES-1:0][ADDR_W-1:0] target_q;
  logic [ENTRIES-1:0][CNT_W-1:0]  cnt;

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             u_hit, u_alloc;

  assign l_idx = IDX_W'(bp_idx(64'(lookup_pc), IDX_W));
  assign l_tag = TAG_W'(bp_tag(64'(lookup_pc), IDX_W));
  assign u_idx = IDX_W'(bp_idx(64'(upd_pc), IDX_W));
  assign u_tag = TAG_W'(bp_tag(64'(upd_pc), IDX_W));

  // rst gating is redundant with the async-cleared valid bits but keeps the outputs quiet in reset.
  assign pred_hit    = lookup_valid & ~rst & valid[l_idx] & (tag_q[l_idx] == l_tag);
  assign pred_taken  = pred_hit & cnt[l_idx][CNT_W-1];
  assign pred_target = pred_taken ? target_q[l_idx] : lookup_pc + ADDR_W'(INST_BYTES);

  assign u_hit   = valid[u_idx] & (tag_q[u_idx] == u_tag);
  assign u_alloc = upd_valid & ~u_hit & upd_taken;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    logic sel;
    assign sel = (u_idx == IDX_W'(i));

    // Flush only drops valid; counter/target writes still land so a later re-alloc is unaffected.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid[i]    <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end else begin
        if (flush)               valid[i] <= 1'b0;
        else if (u_alloc && sel) valid[i] <= 1'b1;
        if (u_alloc && sel) tag_q[i] <= u_tag;
        if (upd_valid && upd_taken && sel) target_q[i] <= upd_target;
      end
    end

    bp_sat_counter #(.CNT_W(CNT_W), .RST_VAL(CNT_WNT)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (upd_valid & u_hit & sel & upd_taken),
      .dec      (upd_valid & u_hit & sel & ~upd_taken),
      .load     (u_alloc & sel),
      .load_val (CNT_WT),
      .cnt      (cnt[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else if (upd_valid) begin
      perf_branches <= PERF_W'(sat_inc(64'(perf_branches), PERF_W));
      if (upd_mispredict)
        perf_mispredicts <= PERF_W'(sat_inc(64'(perf_mispredicts), PERF_W));
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed table-driven bench for branch_predictor_bht plus hand sequences for flush, reset and saturation.
module tb_branch_predictor_bht;

  logic        clk = 0;
  logic        rst = 1;
  logic        lookup_valid = 0;
  logic [31:0] lookup_pc = 0;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 0, upd_taken = 0, upd_mispredict = 0, flush = 0;
  logic [31:0] upd_pc = 0, upd_target = 0;
  logic [31:0] perf_branches, perf_mispredicts;

  // Second instance with 4-bit perf counters for saturation.
  logic        p_upd_valid = 0;
  logic        p_hit, p_taken;
  logic [31:0] p_target;
  logic [3:0]  p_branches, p_mispredicts;

  always #5 clk = ~clk;

  branch_predictor_bht dut (
    .clk(clk), .rst(rst), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .flush(flush),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  branch_predictor_bht #(.PERF_W(4)) dut_p (
    .clk(clk), .rst(rst), .lookup_valid(1'b0), .lookup_pc(32'h0),
    .pred_hit(p_hit), .pred_taken(p_taken), .pred_target(p_target),
    .upd_valid(p_upd_valid), .upd_pc(32'h100), .upd_taken(1'b1), .upd_target(32'h200),
    .upd_mispredict(1'b1), .flush(1'b0),
    .perf_branches(p_branches), .perf_mispredicts(p_mispredicts)
  );

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        ump;
    logic        lv;
    logic [31:0] lpc;
    logic        e_hit;
    logic        e_taken;
    logic [31:0] e_tgt;
  } vec_t;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_lookup(input string name, input logic [31:0] pc,
                              input logic eh, input logic et, input logic [31:0] etgt);
    lookup_valid = 1;
    lookup_pc    = pc;
    #1;
    check({name, ".hit"},    64'(pred_hit),    64'(eh));
    check({name, ".taken"},  64'(pred_taken),  64'(et));
    check({name, ".target"}, 64'(pred_target), 64'(etgt));
  endtask

  // Drive an update for one edge, then observe the lookup one step after the edge.
  task automatic step(input vec_t v, input int n);
    @(negedge clk);
    upd_valid = v.uv; upd_pc = v.upc; upd_taken = v.ut;
    upd_target = v.utgt; upd_mispredict = v.ump;
    @(posedge clk);
    #1;
    upd_valid = 0; upd_mispredict = 0;
    lookup_valid = v.lv;
    lookup_pc    = v.lpc;
    #1;
    check($sformatf("vec%0d.hit", n),    64'(pred_hit),    64'(v.e_hit));
    check($sformatf("vec%0d.taken", n),  64'(pred_taken),  64'(v.e_taken));
    check($sformatf("vec%0d.target", n), 64'(pred_target), 64'(v.e_tgt));
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                     input logic mp, input logic fl);
    @(negedge clk);
    upd_valid = 1; upd_pc = pc; upd_taken = t; upd_target = tgt;
    upd_mispredict = mp; flush = fl;
    @(posedge clk);
    #1;
    upd_valid = 0; upd_mispredict = 0; flush = 0;
  endtask

  vec_t vecs[$];
  int   exp_br, exp_mp;

  initial begin
    //          uv upc      ut utgt     ump lv lpc          hit tk tgt
    vecs.push_back('{0, 32'h0,   0, 32'h0,   0, 1, 32'h100, 0, 0, 32'h104});
    vecs.push_back('{1, 32'h100, 1, 32'h200, 1, 1, 32'h100, 1, 1, 32'h200}); // alloc cnt=2
    vecs.push_back('{1, 32'h100, 0, 32'h0,   1, 1, 32'h100, 1, 0, 32'h104}); // cnt 1
    vecs.push_back('{1, 32'h100, 0, 32'h0,   0, 1, 32'h100, 1, 0, 32'h104}); // cnt 0
    vecs.push_back('{1, 32'h100, 0, 32'h0,   0, 1, 32'h100, 1, 0, 32'h104}); // cnt 0 (clamp)
    vecs.push_back('{1, 32'h100, 1, 32'h200, 0, 1, 32'h100, 1, 0, 32'h104}); // cnt 1
    vecs.push_back('{1, 32'h100, 1, 32'h200, 0, 1, 32'h100, 1, 1, 32'h200}); // cnt 2
    vecs.push_back('{1, 32'h100, 1, 32'h200, 0, 1, 32'h100, 1, 1, 32'h200}); // cnt 3
    vecs.push_back('{1, 32'h100, 1, 32'h200, 0, 1, 32'h100, 1, 1, 32'h200}); // cnt 3 (clamp)
    vecs.push_back('{1, 32'h100, 0, 32'h0,   1, 1, 32'h100, 1, 1, 32'h200}); // cnt 2
    vecs.push_back('{1, 32'h100, 1, 32'h204, 0, 1, 32'h100, 1, 1, 32'h204}); // target rewrite
    vecs.push_back('{0, 32'h0,   0, 32'h0,   0, 1, 32'h140, 0, 0, 32'h144}); // alias miss
    vecs.push_back('{1, 32'h140, 0, 32'h0,   0, 1, 32'h100, 1, 1, 32'h204}); // NT miss: no change
    vecs.push_back('{1, 32'h140, 1, 32'h300, 0, 1, 32'h140, 1, 1, 32'h300}); // replace, cnt=2
    vecs.push_back('{0, 32'h0,   0, 32'h0,   0, 1, 32'h100, 0, 0, 32'h104}); // old tag gone
    vecs.push_back('{1, 32'h140, 0, 32'h0,   1, 1, 32'h140, 1, 0, 32'h144}); // cnt 2->1
    vecs.push_back('{0, 32'h0,   0, 32'h0,   0, 0, 32'h140, 0, 0, 32'h144}); // lookup_valid=0
    vecs.push_back('{0, 32'h0,   0, 32'h0,   0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0}); // wrap
    vecs.push_back('{1, 32'h104, 1, 32'h500, 0, 1, 32'h104, 1, 1, 32'h500}); // other index
    vecs.push_back('{0, 32'h0,   0, 32'h0,   0, 1, 32'h142, 1, 0, 32'h146}); // pc[1:0] ignored

    // Reset state
    #1;
    check_lookup("reset_in", 32'h100, 0, 0, 32'h104);
    check("reset.perf_br", 64'(perf_branches), 0);
    @(negedge clk); rst = 0;
    check_lookup("reset_out", 32'h100, 0, 0, 32'h104);

    exp_br = 0; exp_mp = 0;
    foreach (vecs[i]) begin
      step(vecs[i], i);
      exp_br += int'(vecs[i].uv);
      exp_mp += int'(vecs[i].uv & vecs[i].ump);
    end
    check("tbl.perf_br", 64'(perf_branches), 64'(exp_br));
    check("tbl.perf_mp", 64'(perf_mispredicts), 64'(exp_mp));

    // Same-cycle lookup sees pre-update state; flush wins over a same-cycle taken update
    @(negedge clk); rst = 1; #1; rst = 0;
    @(negedge clk);
    upd_valid = 1; upd_pc = 32'h100; upd_taken = 1; upd_target = 32'h200; upd_mispredict = 0;
    check_lookup("nobypass", 32'h100, 0, 0, 32'h104);
    @(posedge clk); #1; upd_valid = 0;
    upd(32'h108, 1, 32'h280, 1, 0);
    check_lookup("pre_flush", 32'h108, 1, 1, 32'h280);
    upd(32'h10C, 1, 32'h380, 0, 1);
    check_lookup("flush.10c", 32'h10C, 0, 0, 32'h110);
    check_lookup("flush.100", 32'h100, 0, 0, 32'h104);
    check_lookup("flush.108", 32'h108, 0, 0, 32'h10C);
    check("flush.perf_br", 64'(perf_branches), 3);
    check("flush.perf_mp", 64'(perf_mispredicts), 1);

    // Re-alloc after flush, then async reset between edges
    upd(32'h100, 1, 32'h200, 1, 0);
    check_lookup("realloc", 32'h100, 1, 1, 32'h200);
    @(posedge clk); #3;
    rst = 1; #1;
    check_lookup("async_rst", 32'h100, 0, 0, 32'h104);
    check("async_rst.perf_br", 64'(perf_branches), 0);
    check("async_rst.perf_mp", 64'(perf_mispredicts), 0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    check_lookup("post_rst", 32'h100, 0, 0, 32'h104);

    // 4-bit perf counters saturate at 15
    @(negedge clk); p_upd_valid = 1;
    repeat (20) @(posedge clk);
    #1; p_upd_valid = 0;
    check("perf4.branches", 64'(p_branches), 15);
    check("perf4.mispredicts", 64'(p_mispredicts), 15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
